// File: rtl/recv_controller.sv
// recv_controller: serial byte receiver.
// Brings a slow source-clocked serial link (clock, data, byte-start marker)
// into the clk domain, frames bytes with a HUNT/RECV state machine and
// queues them in a small FIFO for a valid/ready consumer. Framing errors
// and FIFO overflow are reported as sticky flags; byteCnt counts every
// byte accepted into the FIFO.
module recv_controller #(
  parameter int FIFO_LOG  = 2,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 n_reset,
  input  logic                 dataClkIn,
  input  logic                 dataIn,
  input  logic                 syncIn,
  output logic [7:0]           rx_byte,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  input  logic                 clrErr,
  output logic                 frameErr,
  output logic                 overflow,
  output logic                 locked,
  output logic [CNT_WIDTH-1:0] byteCnt
);

  localparam int DEPTH = 1 << FIFO_LOG;

  typedef enum logic {HUNT, RECV} state_t;

  // Synchronizer bit order: {link clock, data, sync}
  logic [2:0] meta_q;
  logic [2:0] sync_q;
  logic       link_clk_prev;
  logic       link_edge;
  logic       link_data;
  logic       link_sync;

  state_t     state;
  logic [2:0] bit_cnt;
  logic [6:0] shift;

  logic       wr_en;
  logic       frame_err_set;
  logic [7:0] wr_data;

  logic [7:0]        mem [DEPTH];
  logic [FIFO_LOG:0] wr_ptr;
  logic [FIFO_LOG:0] rd_ptr;
  logic              fifo_full;
  logic              rd_fire;
  logic              wr_fire;

  // Identical two-flop synchronizers keep clock, data and sync aligned,
  // plus one more stage on the clock to find its rising edge.
  // NOTE: every clocked block uses non-blocking (<=) assignments so all
  // flops sample their inputs from the same pre-edge values.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      meta_q        <= '0;
      sync_q        <= '0;
      link_clk_prev <= 1'b0;
    end else begin
      meta_q        <= {dataClkIn, dataIn, syncIn};
      sync_q        <= meta_q;
      link_clk_prev <= sync_q[2];
    end
  end

  assign link_edge = sync_q[2] & ~link_clk_prev;
  assign link_data = sync_q[1];
  assign link_sync = sync_q[0];

  // Decode the framing events produced by a link edge while locked.
  // NOTE: every output gets a default first so no latch is inferred.
  always_comb begin
    wr_en         = 1'b0;
    frame_err_set = 1'b0;
    wr_data       = {shift, link_data};
    if (link_edge && state == RECV) begin
      if (link_sync) begin
        frame_err_set = (bit_cnt != 3'd0);
      end else if (bit_cnt == 3'd0) begin
        frame_err_set = 1'b1;
      end else if (bit_cnt == 3'd7) begin
        wr_en = 1'b1;
      end
    end
  end

  // Framing FSM: hunt for a sync bit, then assemble bytes MSB first.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state   <= HUNT;
      bit_cnt <= 3'd0;
      shift   <= '0;
      locked  <= 1'b0;
    end else if (link_edge) begin
      case (state)
        HUNT: begin
          if (link_sync) begin
            shift   <= {6'd0, link_data};
            bit_cnt <= 3'd1;
            state   <= RECV;
            locked  <= 1'b1;
          end
        end
        RECV: begin
          if (link_sync) begin
            // Start of a byte; an interrupted partial byte is simply dropped.
            shift   <= {6'd0, link_data};
            bit_cnt <= 3'd1;
          end else if (bit_cnt == 3'd0) begin
            state  <= HUNT;
            locked <= 1'b0;
          end else begin
            // bit_cnt wraps 7 -> 0 as the completed byte goes to the FIFO.
            shift   <= {shift[5:0], link_data};
            bit_cnt <= bit_cnt + 3'd1;
          end
        end
        default: begin
          state  <= HUNT;
          locked <= 1'b0;
        end
      endcase
    end
  end

  // FIFO bookkeeping: pointers carry one extra wrap bit to tell full from empty.
  assign rx_valid  = (wr_ptr != rd_ptr);
  assign fifo_full = (wr_ptr[FIFO_LOG] != rd_ptr[FIFO_LOG]) &&
                     (wr_ptr[FIFO_LOG-1:0] == rd_ptr[FIFO_LOG-1:0]);
  assign rd_fire   = rx_valid & rx_ready;
  assign wr_fire   = wr_en & (~fifo_full | rd_fire);
  assign rx_byte   = rx_valid ? mem[rd_ptr[FIFO_LOG-1:0]] : 8'h00;

  // FIFO storage.
  // NOTE: the array has no reset; empty-ness comes from the pointers and
  // rx_byte is masked while empty, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_ptr[FIFO_LOG-1:0]] <= wr_data;
    end
  end

  // Pointers, sticky flags and the accepted-byte counter.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      frameErr <= 1'b0;
      overflow <= 1'b0;
      byteCnt  <= '0;
    end else begin
      if (wr_fire) begin
        wr_ptr  <= wr_ptr + 1'b1;
        byteCnt <= byteCnt + 1'b1;
      end
      if (rd_fire) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      // A fresh error in the same cycle as clrErr keeps the flag set.
      frameErr <= frame_err_set | (frameErr & ~clrErr);
      overflow <= (wr_en & fifo_full & ~rd_fire) | (overflow & ~clrErr);
    end
  end

endmodule

// File: tb/tb_recv_controller.sv
// tb_recv_controller: drives the serial link, consumes the FIFO and checks
// received bytes, flags and counters against a stream-level reference model.
module tb_recv_controller;

  logic        clk = 1'b0;
  logic        n_reset;
  logic        dataClkIn;
  logic        dataIn;
  logic        syncIn;
  logic        rx_ready;
  logic        clrErr;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic        frameErr;
  logic        overflow;
  logic        locked;
  logic [15:0] byteCnt;

  // Narrow-counter instance, used only to see byteCnt wrap quickly.
  logic [7:0]  w_rx_byte;
  logic        w_rx_valid;
  logic        w_frameErr;
  logic        w_overflow;
  logic        w_locked;
  logic [2:0]  w_byteCnt;

  int vectors     = 0;
  int miscompares = 0;
  int ready_mode  = 0;   // 0: never ready, 1: always ready, 2: random

  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  bit         st_d[$];
  bit         st_s[$];
  bit         exp_err;

  recv_controller dut (
    .clk(clk), .n_reset(n_reset), .dataClkIn(dataClkIn), .dataIn(dataIn),
    .syncIn(syncIn), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .clrErr(clrErr), .frameErr(frameErr),
    .overflow(overflow), .locked(locked), .byteCnt(byteCnt)
  );

  recv_controller #(.FIFO_LOG(2), .CNT_WIDTH(3)) dut_w (
    .clk(clk), .n_reset(n_reset), .dataClkIn(dataClkIn), .dataIn(dataIn),
    .syncIn(syncIn), .rx_byte(w_rx_byte), .rx_valid(w_rx_valid),
    .rx_ready(rx_ready), .clrErr(clrErr), .frameErr(w_frameErr),
    .overflow(w_overflow), .locked(w_locked), .byteCnt(w_byteCnt)
  );

  always #5 clk = ~clk;

  // Consumer: choose rx_ready for the coming edge, log each handshake.
  always @(negedge clk) begin
    case (ready_mode)
      0:       rx_ready = 1'b0;
      1:       rx_ready = 1'b1;
      default: rx_ready = 1'($urandom_range(0, 1));
    endcase
    if (n_reset === 1'b1 && rx_valid === 1'b1 && rx_ready === 1'b1)
      got_q.push_back(rx_byte);
  end

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset;
    n_reset    = 1'b0;
    dataClkIn  = 1'b0;
    dataIn     = 1'b0;
    syncIn     = 1'b0;
    clrErr     = 1'b0;
    ready_mode = 0;
    settle(3);
    n_reset = 1'b1;
    settle(3);
    got_q.delete();
  endtask

  // One link bit: data/sync set with the link clock low, then a rising edge.
  task automatic send_bit(input bit d, input bit s, input int half);
    dataIn    = d;
    syncIn    = s;
    dataClkIn = 1'b0;
    settle(half);
    dataClkIn = 1'b1;
    settle(half);
  endtask

  task automatic send_byte(input logic [7:0] b, input int half);
    for (int i = 7; i >= 0; i--) send_bit(b[i], i == 7, half);
  endtask

  task automatic pulse_clr;
    clrErr = 1'b1;
    settle(1);
    clrErr = 1'b0;
    settle(1);
  endtask

  // Reference model over the whole bit stream: every sync opens a byte;
  // eight bits with no further sync make a byte, a sync inside those eight
  // is a framing error, and any non-sync bit straight after a complete byte
  // is a framing error (the receiver drops back to hunting).
  task automatic model_stream;
    int syncs[$];
    exp_q.delete();
    exp_err = 1'b0;
    for (int i = 0; i < st_s.size(); i++) if (st_s[i]) syncs.push_back(i);
    for (int k = 0; k < syncs.size(); k++) begin
      int p, q;
      logic [7:0] b;
      p = syncs[k];
      q = (k + 1 < syncs.size()) ? syncs[k+1] : st_s.size();
      if (q - p >= 8) begin
        b = '0;
        for (int j = 0; j < 8; j++) b = {b[6:0], 1'(st_d[p+j])};
        exp_q.push_back(b);
        if (q - p > 8) exp_err = 1'b1;
      end else if (k + 1 < syncs.size()) begin
        exp_err = 1'b1;
      end
    end
  endtask

  task automatic test_reset;
    n_reset   = 1'b0;
    dataClkIn = 1'b0;
    dataIn    = 1'b0;
    syncIn    = 1'b0;
    clrErr    = 1'b0;
    settle(2);
    vectors++; if (rx_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); end
    vectors++; if (rx_byte !== 8'h00) begin miscompares++; $display("FAIL reset_rx_byte: got %h expected 00", rx_byte); end
    vectors++; if (frameErr !== 1'b0) begin miscompares++; $display("FAIL reset_frameErr: got %b expected 0", frameErr); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL reset_locked: got %b expected 0", locked); end
    vectors++; if (byteCnt !== 16'h0) begin miscompares++; $display("FAIL reset_byteCnt: got %h expected 0000", byteCnt); end
    n_reset = 1'b1;
    settle(2);
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp [2] = '{8'hA5, 8'h3C};
    do_reset();
    ready_mode = 1;
    send_byte(8'hA5, 4);
    send_byte(8'h3C, 4);
    settle(8);
    vectors++; if (got_q.size() != 2) begin miscompares++; $display("FAIL b2b_count: got %0d expected 2", got_q.size()); end
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (i >= got_q.size() || got_q[i] !== exp[i]) begin
        miscompares++; $display("FAIL b2b_byte%0d: got %h expected %h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp[i]);
      end
    end
    vectors++; if (byteCnt !== 16'd2) begin miscompares++; $display("FAIL b2b_byteCnt: got %0d expected 2", byteCnt); end
    vectors++; if (locked !== 1'b1) begin miscompares++; $display("FAIL b2b_locked: got %b expected 1", locked); end
    vectors++; if (frameErr !== 1'b0 || overflow !== 1'b0) begin miscompares++; $display("FAIL b2b_flags: got %b%b expected 00", frameErr, overflow); end
  endtask

  task automatic test_garbage;
    do_reset();
    ready_mode = 1;
    send_bit(1'b1, 1'b0, 3);
    send_bit(1'b0, 1'b0, 3);
    send_bit(1'b1, 1'b0, 3);
    vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL garbage_locked: got %b expected 0", locked); end
    send_byte(8'h81, 3);
    settle(8);
    vectors++; if (got_q.size() != 1 || got_q[0] !== 8'h81) begin miscompares++; $display("FAIL garbage_byte: got %0d bytes first %h expected 1 byte 81", got_q.size(), got_q[0]); end
    vectors++; if (frameErr !== 1'b0) begin miscompares++; $display("FAIL garbage_frameErr: got %b expected 0", frameErr); end
    vectors++; if (byteCnt !== 16'd1) begin miscompares++; $display("FAIL garbage_byteCnt: got %0d expected 1", byteCnt); end
  endtask

  task automatic test_resync;
    do_reset();
    ready_mode = 1;
    send_bit(1'b1, 1'b1, 4);
    send_bit(1'b1, 1'b0, 4);
    send_bit(1'b0, 1'b0, 4);
    send_byte(8'h55, 4);
    settle(8);
    vectors++; if (frameErr !== 1'b1) begin miscompares++; $display("FAIL resync_frameErr: got %b expected 1", frameErr); end
    vectors++; if (got_q.size() != 1 || got_q[0] !== 8'h55) begin miscompares++; $display("FAIL resync_byte: got %0d bytes first %h expected 1 byte 55", got_q.size(), got_q[0]); end
    vectors++; if (byteCnt !== 16'd1) begin miscompares++; $display("FAIL resync_byteCnt: got %0d expected 1", byteCnt); end
    pulse_clr();
    vectors++; if (frameErr !== 1'b0) begin miscompares++; $display("FAIL resync_clr: got %b expected 0", frameErr); end
  endtask

  task automatic test_overflow;
    logic [7:0] sent [6] = '{8'h10, 8'hE1, 8'h32, 8'hC3, 8'h54, 8'h65};
    do_reset();
    ready_mode = 0;
    for (int i = 0; i < 6; i++) send_byte(sent[i], 3);
    settle(4);
    vectors++; if (byteCnt !== 16'd4) begin miscompares++; $display("FAIL ovf_byteCnt: got %0d expected 4", byteCnt); end
    vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
    vectors++; if (rx_valid !== 1'b1 || rx_byte !== 8'h10) begin miscompares++; $display("FAIL ovf_head: got %b/%h expected 1/10", rx_valid, rx_byte); end
    ready_mode = 1;
    settle(10);
    vectors++; if (got_q.size() != 4) begin miscompares++; $display("FAIL ovf_count: got %0d expected 4", got_q.size()); end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (i >= got_q.size() || got_q[i] !== sent[i]) begin
        miscompares++; $display("FAIL ovf_byte%0d: got %h expected %h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, sent[i]);
      end
    end
    vectors++; if (overflow !== 1'b1 || rx_valid !== 1'b0) begin miscompares++; $display("FAIL ovf_sticky: got ovf %b valid %b expected 1 0", overflow, rx_valid); end
    pulse_clr();
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_clr: got %b expected 0", overflow); end
  endtask

  task automatic test_reset_mid_byte;
    do_reset();
    ready_mode = 0;
    send_byte(8'h11, 4);
    for (int i = 7; i >= 3; i--) send_bit(1'(8'hAB >> i), i == 7, 4);
    n_reset = 1'b0;
    settle(2);
    vectors++; if (rx_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_rx_valid: got %b expected 0", rx_valid); end
    vectors++; if (locked !== 1'b0 || byteCnt !== 16'd0) begin miscompares++; $display("FAIL midrst_state: got locked %b cnt %0d expected 0 0", locked, byteCnt); end
    n_reset = 1'b1;
    settle(6);
    ready_mode = 1;
    send_byte(8'hF0, 4);
    settle(8);
    vectors++; if (got_q.size() != 1 || got_q[0] !== 8'hF0) begin miscompares++; $display("FAIL midrst_byte: got %0d bytes first %h expected 1 byte f0", got_q.size(), got_q[0]); end
    vectors++; if (byteCnt !== 16'd1) begin miscompares++; $display("FAIL midrst_byteCnt: got %0d expected 1", byteCnt); end
  endtask

  task automatic test_count_wrap;
    do_reset();
    ready_mode = 1;
    for (int i = 0; i < 7; i++) send_byte(8'($urandom), 2);
    settle(6);
    vectors++; if (w_byteCnt !== 3'd7) begin miscompares++; $display("FAIL wrap_max: got %0d expected 7", w_byteCnt); end
    send_byte(8'($urandom), 2);
    settle(6);
    vectors++; if (w_byteCnt !== 3'd0) begin miscompares++; $display("FAIL wrap_zero: got %0d expected 0", w_byteCnt); end
    vectors++; if (byteCnt !== 16'd8) begin miscompares++; $display("FAIL wrap_wide: got %0d expected 8", byteCnt); end
  endtask

  task automatic test_random;
    for (int it = 0; it < 6; it++) begin
      do_reset();
      ready_mode = 2;
      st_d.delete();
      st_s.delete();
      for (int seg = 0; seg < 8; seg++) begin
        int kind, n;
        kind = $urandom_range(0, 3);
        if (kind <= 1) n = 8;
        else if (kind == 2) n = $urandom_range(1, 7);
        else n = $urandom_range(1, 3);
        for (int j = 0; j < n; j++) begin
          st_d.push_back(1'($urandom));
          st_s.push_back(kind != 3 && j == 0);
        end
      end
      model_stream();
      for (int i = 0; i < st_d.size(); i++) send_bit(st_d[i], st_s[i], $urandom_range(2, 4));
      settle(6);
      ready_mode = 1;
      settle(10);
      vectors++; if (got_q.size() != exp_q.size()) begin miscompares++; $display("FAIL rand%0d_count: got %0d expected %0d", it, got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
        vectors++;
        if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
          miscompares++; $display("FAIL rand%0d_byte%0d: got %h expected %h", it, i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
        end
      end
      vectors++; if (frameErr !== exp_err) begin miscompares++; $display("FAIL rand%0d_frameErr: got %b expected %b", it, frameErr, exp_err); end
      vectors++; if (byteCnt !== 16'(exp_q.size())) begin miscompares++; $display("FAIL rand%0d_byteCnt: got %0d expected %0d", it, byteCnt, exp_q.size()); end
      vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL rand%0d_overflow: got %b expected 0", it, overflow); end
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_garbage();
    test_resync();
    test_overflow();
    test_reset_mid_byte();
    test_count_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/recv_controller.md
RECV_CONTROLLER -- requirements
Module: recv_controller

Interface
REQ-001 SHALL have parameter FIFO_LOG, default 2, meaning the receive FIFO holds 2^FIFO_LOG bytes.
REQ-002 SHALL have parameter CNT_WIDTH, default 16, meaning the width of byteCnt.
REQ-003 SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 SHALL have port n_reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port dataClkIn  input  1  serial link clock from the differential input buffer; asynchronous to clk.
REQ-006 SHALL have port dataIn  input  1  serial data, valid at rising dataClkIn.
REQ-007 SHALL have port syncIn  input  1  byte-start marker, valid at rising dataClkIn.
REQ-008 SHALL have port rx_byte  output  8  FIFO head byte.
REQ-009 SHALL have port rx_valid  output  1  high when the FIFO is non-empty.
REQ-010 SHALL have port rx_ready  input  1  consumer accepts rx_byte.
REQ-011 SHALL have port clrErr  input  1  clears the sticky flags.
REQ-012 SHALL have port frameErr  output  1  sticky framing error.
REQ-013 SHALL have port overflow  output  1  sticky FIFO overflow.
REQ-014 SHALL have port locked  output  1  high while the FSM is in RECV.
REQ-015 SHALL have port byteCnt  output  CNT_WIDTH  count of bytes written into the FIFO.

Function
REQ-016 SHALL pass dataClkIn, dataIn and syncIn through identical 2-flop synchronizers, so the three sampled signals stay mutually aligned.
REQ-017 SHALL define a link edge as the single clk cycle where synchronized dataClkIn is 1 and its registered previous value is 0; data and sync SHALL be sampled in that cycle.
REQ-018 SHALL support a link protocol with each dataClkIn phase lasting at least 2 clk periods, MSB first, and syncIn=1 only on bit 7 of each byte; behaviour for faster links is undefined.
REQ-019 SHALL implement a 2-state FSM, HUNT and RECV, holding a shift register and a 3-bit bit counter bitCnt.
REQ-020 In HUNT, an edge with sync=0 SHALL be ignored.
REQ-021 In HUNT, an edge with sync=1 SHALL load the data bit as the MSB, set bitCnt=1 and enter RECV.
REQ-022 In RECV, an edge with sync=0 and bitCnt in 1..7 SHALL shift the data bit in and increment bitCnt.
REQ-023 In RECV, the edge at bitCnt=7 SHALL write {shift[6:0],data} into the FIFO on that same clk edge and SHALL set bitCnt=0.
REQ-024 In RECV, an edge with sync=1 and bitCnt=0 SHALL start the next byte: load the MSB and set bitCnt=1.
REQ-025 In RECV, an edge with sync=1 and bitCnt≠0 SHALL set frameErr, discard the partial byte, load the MSB, set bitCnt=1 and stay in RECV.
REQ-026 In RECV, an edge with sync=0 and bitCnt=0 SHALL set frameErr and go to HUNT.
REQ-027 SHALL assert rx_valid in the clk cycle after a write into an empty FIFO.
REQ-028 SHALL complete a read when rx_valid and rx_ready are both high; the head SHALL advance at that clk edge, and rx_byte SHALL be don't-care while rx_valid=0.
REQ-029 SHALL drop the byte on a write while full with no read that cycle, and SHALL set overflow.
REQ-030 SHALL accept both transfers on a simultaneous write and read while full, with no overflow.
REQ-031 SHALL accept both transfers on a simultaneous write and read while empty, with rx_valid rising next cycle.
REQ-032 SHALL increment byteCnt on each accepted FIFO write only, wrapping modulo 2^CNT_WIDTH.
REQ-033 clrErr SHALL clear frameErr and overflow next cycle.
REQ-034 A new error coinciding with clrErr SHALL win, leaving the flag set.

Reset
REQ-035 SHALL, while n_reset=0, asynchronously force the FSM to HUNT, bitCnt=0, FIFO empty, rx_valid=0, rx_byte=0, frameErr=0, overflow=0, locked=0, byteCnt=0, and all synchronizer flops to 0.
REQ-036 SHALL discard any partial byte and all FIFO contents on a reset mid-byte, and SHALL resume in HUNT after n_reset releases.

Verification
REQ-037 SHALL pass: bytes 0xA5, 0x3C sent back-to-back with link period 8 clk and rx_ready=1 -> rx_byte 0xA5 then 0x3C, byteCnt=2, locked=1, no flags.
REQ-038 SHALL pass: 3 garbage bits with sync=0, then 0x81 with sync -> garbage ignored, one byte 0x81.
REQ-039 SHALL pass: sync reasserted at bit 4 of a byte, then a full 0x55 -> frameErr=1, partial byte dropped, only 0x55 output, byteCnt=1.
REQ-040 SHALL pass: 6 bytes with rx_ready=0 and FIFO_LOG=2 -> first 4 bytes retained in order, overflow=1, byteCnt=4; clrErr pulse -> overflow=0.
REQ-041 SHALL pass: n_reset pulsed low after bit 5 of a byte, then 0xF0 sent -> rx_valid=0 during reset, only 0xF0 received, byteCnt=1.
REQ-042 SHALL pass: byteCnt preloaded at 0xFFFF via 65535 bytes, one more byte sent -> byteCnt=0x0000.
